// File: rtl/mdu_ctrl_pkg.sv
// Shared MDU op codes and default latencies for the decoder, the hazard unit and the MDU.
package mdu_ctrl_pkg;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MFHI  = 4'd5;
  localparam logic [3:0] MD_MFLO  = 4'd6;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // True for the multi-cycle ops that start a busy countdown.
  function automatic logic is_md_start(input logic [3:0] op);
    return (op >= MD_MULT) && (op <= MD_DIVU);
  endfunction

endpackage

// File: rtl/mdu_ctrl_arith.sv
// Combinational multiply/divide datapath: op, a, b -> {hi, lo} plus a divide-by-zero flag.
module mdu_arith
  import mdu_ctrl_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo,
  output logic        o_div0
);

  logic [63:0] w_sprod;
  logic [63:0] w_uprod;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [31:0] w_den_s;
  logic [31:0] w_den_u;
  logic [31:0] w_mag_q;
  logic [31:0] w_mag_r;
  logic [31:0] w_uq;
  logic [31:0] w_ur;

  assign w_sprod = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
  assign w_uprod = {32'd0, i_a} * {32'd0, i_b};

  // Signed divide runs on magnitudes; 0x80000000 / -1 then wraps to 0x80000000 rem 0.
  assign w_abs_a = i_a[31] ? -i_a : i_a;
  assign w_abs_b = i_b[31] ? -i_b : i_b;
  assign w_den_s = (i_b == 32'd0) ? 32'd1 : w_abs_b;
  assign w_den_u = (i_b == 32'd0) ? 32'd1 : i_b;
  assign w_mag_q = w_abs_a / w_den_s;
  assign w_mag_r = w_abs_a % w_den_s;
  assign w_uq    = i_a / w_den_u;
  assign w_ur    = i_a % w_den_u;

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    o_hi   = '0;
    o_lo   = '0;
    o_div0 = 1'b0;
    case (i_op)
      MD_MULT:  {o_hi, o_lo} = w_sprod;
      MD_MULTU: {o_hi, o_lo} = w_uprod;
      MD_DIV: begin
        o_lo   = (i_a[31] ^ i_b[31]) ? -w_mag_q : w_mag_q;
        o_hi   = i_a[31] ? -w_mag_r : w_mag_r;
        o_div0 = (i_b == 32'd0);
      end
      MD_DIVU: begin
        o_lo   = w_uq;
        o_hi   = w_ur;
        o_div0 = (i_b == 32'd0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// MDU sequencer: owns HI/LO, runs MULT/DIV with a busy countdown, serves MF/MT and the D-stage stall.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  e_md_op,
  input  logic [31:0] e_rs,
  input  logic [31:0] e_rt,
  input  logic        d_md_use,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_rd
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  logic [CW-1:0] r_cnt;
  logic          r_busy;
  logic [3:0]    r_op;
  logic [31:0]   r_a;
  logic [31:0]   r_b;
  logic [31:0]   r_hi;
  logic [31:0]   r_lo;

  logic          w_state;
  logic          w_start;
  logic [31:0]   w_res_hi;
  logic [31:0]   w_res_lo;
  logic          w_div0;

  assign w_state = (r_cnt != '0) ? ST_RUN : ST_IDLE;
  assign w_start = is_md_start(e_md_op);

  mdu_arith u_arith (
    .i_op   (r_op),
    .i_a    (r_a),
    .i_b    (r_b),
    .o_hi   (w_res_hi),
    .o_lo   (w_res_lo),
    .o_div0 (w_div0)
  );

  // NOTE: sequential state uses non-blocking assignments; the operand latches are
  // plain registers (not a memory array), so they are reset along with everything else.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_op   <= MD_NONE;
      r_a    <= '0;
      r_b    <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
    end else begin
      case (w_state)
        ST_IDLE: begin
          if (w_start) begin
            r_op   <= e_md_op;
            r_a    <= e_rs;
            r_b    <= e_rt;
            r_cnt  <= (e_md_op == MD_DIV || e_md_op == MD_DIVU) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            r_busy <= 1'b1;
          end else if (e_md_op == MD_MTHI) begin
            r_hi <= e_rs;
          end else if (e_md_op == MD_MTLO) begin
            r_lo <= e_rs;
          end
        end
        default: begin
          // Ops arriving while busy are ignored; the pipeline never sends them.
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_busy <= 1'b0;
            if (!w_div0) begin
              r_hi <= w_res_hi;
              r_lo <= w_res_lo;
            end
          end
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign hi       = r_hi;
  assign lo       = r_lo;
  assign md_stall = d_md_use & (r_busy | w_start);
  assign md_rd    = (e_md_op == MD_MFHI) ? r_hi :
                    (e_md_op == MD_MFLO) ? r_lo : 32'd0;

endmodule
